// File: rtl/feature_window_scheduler_if.sv
// Signal bundle between the window scheduler and its count source, NN engine and host FIFO.
// master is the scheduler side; slave is the environment side.
interface feature_window_scheduler_if #(
    parameter int unsigned ADDR_W = 5
);
    logic                i_enable;
    logic [7:0]          i_count_feature;
    logic                i_count_valid;
    logic [ADDR_W-1:0]   o_nn_addr;
    logic signed [7:0]   o_nn_data;
    logic                o_nn_we;
    logic                o_nn_valid;
    logic                o_nn_start;
    logic                i_nn_done;
    logic [7:0]          i_nn_predicted_class;
    logic                o_fifo_input_valid;
    logic [15:0]         o_fifo_input_data;
    logic                i_fifo_ready_for_input;
    logic                o_busy;
    logic [7:0]          o_drop_count;

    modport master (
        input  i_enable, i_count_feature, i_count_valid, i_nn_done,
               i_nn_predicted_class, i_fifo_ready_for_input,
        output o_nn_addr, o_nn_data, o_nn_we, o_nn_valid, o_nn_start,
               o_fifo_input_valid, o_fifo_input_data, o_busy, o_drop_count
    );

    modport slave (
        output i_enable, i_count_feature, i_count_valid, i_nn_done,
               i_nn_predicted_class, i_fifo_ready_for_input,
        input  o_nn_addr, o_nn_data, o_nn_we, o_nn_valid, o_nn_start,
               o_fifo_input_valid, o_fifo_input_data, o_busy, o_drop_count
    );
endinterface

// File: rtl/feature_window_scheduler.sv
// Sliding window of count features; loads each full window into the NN oldest-first,
// starts inference and pushes {class, latest count} to the host FIFO.
module feature_window_scheduler #(
    parameter int unsigned WINDOW     = 16,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NN_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    feature_window_scheduler_if.master bus
);
    localparam int unsigned PTR_W  = $clog2(WINDOW);
    localparam int unsigned SUM_W  = PTR_W + 1;
    localparam int unsigned FILL_W = $clog2(WINDOW + 1);
    localparam int unsigned TO_W   = $clog2(NN_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_PUSH} state_t;

    state_t             state_q, state_d;
    logic [7:0]         buffer_q [WINDOW];
    logic               buf_we;
    logic [PTR_W-1:0]   buf_waddr;
    logic [7:0]         buf_wdata;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, k_q, k_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               pend_valid_q, pend_valid_d;
    logic [7:0]         pend_data_q, pend_data_d;
    logic [7:0]         last_q, last_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [7:0]         drop_q, drop_d;
    logic [ADDR_W-1:0]  nn_addr_q, nn_addr_d;
    logic [7:0]         nn_data_q, nn_data_d;
    logic               nn_we_q, nn_we_d, start_q, start_d;
    logic               fifo_valid_q, fifo_valid_d, busy_q, busy_d;
    logic [15:0]        fifo_data_q, fifo_data_d;
    logic [7:0]         feat;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WINDOW - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // (base + off) mod WINDOW without requiring a power-of-two window
    function automatic logic [PTR_W-1:0] win_idx(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
        logic [SUM_W-1:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= SUM_W'(WINDOW)) s = s - SUM_W'(WINDOW);
        return s[PTR_W-1:0];
    endfunction

    // NN inputs are signed, so counts above 127 clip
    function automatic logic [7:0] clip_s8(input logic [7:0] v);
        return v[7] ? 8'd127 : v;
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        fill_d       = fill_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        last_d       = last_q;
        to_d         = to_q;
        drop_d       = drop_q;
        nn_addr_d    = nn_addr_q;
        nn_data_d    = nn_data_q;
        nn_we_d      = 1'b0;
        start_d      = 1'b0;
        fifo_valid_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        buf_we       = 1'b0;
        buf_waddr    = wr_ptr_q;
        buf_wdata    = 8'h00;
        feat         = 8'h00;

        // features arriving while busy park in the one-entry pending slot
        if (state_q != S_IDLE && bus.i_count_valid) begin
            pend_valid_d = 1'b1;
            pend_data_d  = bus.i_count_feature;
            if (pend_valid_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!bus.i_enable) begin
                    fill_d       = '0;
                    wr_ptr_d     = '0;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q || bus.i_count_valid) begin
                    feat         = pend_valid_q ? pend_data_q : bus.i_count_feature;
                    pend_valid_d = pend_valid_q && bus.i_count_valid;
                    if (bus.i_count_valid) pend_data_d = bus.i_count_feature;
                    buf_we    = 1'b1;
                    buf_wdata = feat;
                    wr_ptr_d  = wrap_inc(wr_ptr_q);
                    if (fill_q != FILL_W'(WINDOW)) fill_d = fill_q + FILL_W'(1);
                    if (fill_q >= FILL_W'(WINDOW - 1)) begin
                        state_d   = S_LOAD;
                        last_d    = feat;
                        k_d       = '0;
                        nn_we_d   = 1'b1;
                        nn_addr_d = '0;
                        nn_data_d = clip_s8(buffer_q[wr_ptr_d]);
                    end
                end
            end
            S_LOAD: begin
                if (k_q == PTR_W'(WINDOW - 1)) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    k_d       = k_q + PTR_W'(1);
                    nn_we_d   = 1'b1;
                    nn_addr_d = ADDR_W'(k_d);
                    nn_data_d = clip_s8(buffer_q[win_idx(wr_ptr_q, k_d)]);
                end
            end
            S_START: begin
                state_d = S_WAIT;
                to_d    = '0;
            end
            S_WAIT: begin
                if (bus.i_nn_done) begin
                    state_d      = S_PUSH;
                    fifo_valid_d = 1'b1;
                    fifo_data_d  = {bus.i_nn_predicted_class, last_q};
                end else if (to_q == TO_W'(NN_TIMEOUT - 1)) begin
                    state_d      = S_PUSH;
                    fifo_valid_d = 1'b1;
                    fifo_data_d  = {8'hFF, last_q};
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_PUSH: begin
                if (bus.i_fifo_ready_for_input) state_d = S_IDLE;
                else fifo_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < WINDOW; i++) buffer_q[i] <= 8'h00;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            fill_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            last_q       <= 8'h00;
            to_q         <= '0;
            drop_q       <= 8'h00;
            nn_addr_q    <= '0;
            nn_data_q    <= 8'h00;
            nn_we_q      <= 1'b0;
            start_q      <= 1'b0;
            fifo_valid_q <= 1'b0;
            fifo_data_q  <= 16'h0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (buf_we) buffer_q[buf_waddr] <= buf_wdata;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            fill_q       <= fill_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            last_q       <= last_d;
            to_q         <= to_d;
            drop_q       <= drop_d;
            nn_addr_q    <= nn_addr_d;
            nn_data_q    <= nn_data_d;
            nn_we_q      <= nn_we_d;
            start_q      <= start_d;
            fifo_valid_q <= fifo_valid_d;
            fifo_data_q  <= fifo_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_nn_addr          = nn_addr_q;
    assign bus.o_nn_data          = nn_data_q;
    assign bus.o_nn_we            = nn_we_q;
    assign bus.o_nn_valid         = nn_we_q;
    assign bus.o_nn_start         = start_q;
    assign bus.o_fifo_input_valid = fifo_valid_q;
    assign bus.o_fifo_input_data  = fifo_data_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_drop_count       = drop_q;
endmodule
